// File: rtl/irq_scheduler_if.sv
// Peripheral/CPU/bus signal bundle for the interrupt scheduler.
// The master side is the system (peripherals, CPU, bus host); the slave side is the scheduler.
interface irq_scheduler_if #(
    parameter int unsigned NumIrq = 4
);
    logic [NumIrq-1:0] irq_req;
    logic [NumIrq-1:0] cpu_irq_raise;
    logic [NumIrq-1:0] cpu_irq_ack;
    logic [7:0]        bus_addr;
    logic [7:0]        bus_wdata;
    logic              bus_we;
    logic [7:0]        bus_rdata;
    logic              bus_rd_hit;

    modport master (
        output irq_req, cpu_irq_ack, bus_addr, bus_wdata, bus_we,
        input  cpu_irq_raise, bus_rdata, bus_rd_hit
    );

    modport slave (
        input  irq_req, cpu_irq_ack, bus_addr, bus_wdata, bus_we,
        output cpu_irq_raise, bus_rdata, bus_rd_hit
    );
endinterface

// File: rtl/irq_scheduler.sv
// Interrupt scheduler: edge capture, bus-programmable mask, fixed/round-robin winner selection,
// one-hot raise held until the CPU acknowledges. Small register block at BaseAddr+0..+2.
module irq_scheduler #(
    parameter int unsigned NumIrq   = 4,
    parameter logic [7:0]  BaseAddr = 8'hE0
) (
    input logic            clk_i,
    input logic            reset_ni,
    irq_scheduler_if.slave bus
);
    localparam int unsigned IdxW  = (NumIrq > 1) ? $clog2(NumIrq) : 1;
    localparam int unsigned ScanW = IdxW + 1;

    typedef enum logic [1:0] {StIdle, StRaise, StGap} state_e;

    state_e            state_q;
    logic [NumIrq-1:0] mask_q, pending_q, req_q, raise_q;
    logic              mode_q;
    logic [IdxW-1:0]   rr_ptr_q, win_q;
    logic [7:0]        rdata_q;
    logic              rd_hit_q;

    logic [NumIrq-1:0] elig, rise, w1c, ack_clr, pending_d, win_oh;
    logic              hit_mask, hit_pend, hit_mode, rd_valid, ack_done, win_found;
    logic [IdxW-1:0]   win_idx, start, rr_next;
    logic [ScanW-1:0]  scan;
    logic [7:0]        rdata_d;

    always_comb begin
        hit_mask  = bus.bus_addr == BaseAddr;
        hit_pend  = bus.bus_addr == BaseAddr + 8'd1;
        hit_mode  = bus.bus_addr == BaseAddr + 8'd2;
        rd_valid  = !bus.bus_we && (hit_mask || hit_pend || hit_mode);
        rise      = bus.irq_req & ~req_q;
        elig      = pending_q & mask_q;
        ack_done  = (state_q == StRaise) && bus.cpu_irq_ack[win_q];
        w1c       = (bus.bus_we && hit_pend) ? bus.bus_wdata[NumIrq-1:0] : '0;
        ack_clr   = '0;
        if (ack_done) ack_clr[win_q] = 1'b1;
        // A new edge outranks both W1C and the acknowledge clear.
        pending_d = (pending_q & ~(w1c | ack_clr)) | rise;
        rr_next   = (win_q == IdxW'(NumIrq - 1)) ? '0 : win_q + IdxW'(1);
        rdata_d   = '0;
        if (hit_mask) rdata_d = 8'(mask_q);
        if (hit_pend) rdata_d = 8'(pending_q);
        if (hit_mode) rdata_d = {7'b0, mode_q};
    end

    // Scan elig starting at rr_ptr (round-robin) or 0 (fixed), wrapping at NumIrq.
    always_comb begin
        start     = mode_q ? rr_ptr_q : '0;
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int unsigned k = 0; k < NumIrq; k++) begin
            scan = ScanW'(start) + ScanW'(k);
            if (scan >= ScanW'(NumIrq)) scan = scan - ScanW'(NumIrq);
            if (!win_found && elig[scan[IdxW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[IdxW-1:0];
            end
        end
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q   <= StIdle;
            mask_q    <= '1;
            pending_q <= '0;
            req_q     <= '0;
            raise_q   <= '0;
            mode_q    <= 1'b0;
            rr_ptr_q  <= '0;
            win_q     <= '0;
            rdata_q   <= '0;
            rd_hit_q  <= 1'b0;
        end else begin
            req_q     <= bus.irq_req;
            pending_q <= pending_d;
            if (bus.bus_we && hit_mask) mask_q <= bus.bus_wdata[NumIrq-1:0];
            if (bus.bus_we && hit_mode) mode_q <= bus.bus_wdata[0];
            rd_hit_q <= rd_valid;
            rdata_q  <= rd_valid ? rdata_d : '0;
            case (state_q)
                StIdle: begin
                    if (win_found) begin
                        win_q   <= win_idx;
                        raise_q <= win_oh;
                        state_q <= StRaise;
                    end
                end
                StRaise: begin
                    if (ack_done) begin
                        raise_q  <= '0;
                        rr_ptr_q <= rr_next;
                        state_q  <= StGap;
                    end
                end
                StGap:   state_q <= StIdle;
                default: begin
                    raise_q <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.cpu_irq_raise = raise_q;
    assign bus.bus_rdata     = rdata_q;
    assign bus.bus_rd_hit    = rd_hit_q;
endmodule

// File: tb/tb_irq_scheduler.sv
// Directed and randomized bench for irq_scheduler against a behavioural model of the
// scheduler's rules (pending set, mask, selection order, ack/gap sequencing).
module tb_irq_scheduler;
    localparam int unsigned N = 4;
    localparam logic [7:0]  Base = 8'hE0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    irq_scheduler_if #(.NumIrq(N)) bus ();

    irq_scheduler #(.NumIrq(N), .BaseAddr(Base)) dut (
        .clk_i   (clk),
        .reset_ni(reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: srv = source currently raised (-1 none), gap = quiet cycle after ack.
    bit [3:0] m_mask, m_pend, m_req_prev;
    bit       m_mode, m_gap, m_hit;
    int       m_rr, m_srv;
    bit [7:0] m_rdata;

    function automatic int pick(input bit [3:0] elig, input bit mode, input int rr);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = mode ? (rr + k) % N : k;
            if (elig[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit [3:0] exp_raise();
        bit [3:0] r;
        r = '0;
        if (m_srv >= 0) r[m_srv] = 1'b1;
        return r;
    endfunction

    task automatic model_step();
        bit [3:0] req, ack, clr, old_pend, old_mask;
        bit       old_mode, done, we;
        int       offs;
        if (!reset_n) begin
            m_mask = 4'hF; m_pend = '0; m_req_prev = '0; m_mode = 0;
            m_gap = 0; m_hit = 0; m_rr = 0; m_srv = -1; m_rdata = '0;
        end else begin
            req = bus.irq_req; ack = bus.cpu_irq_ack; we = bus.bus_we;
            old_pend = m_pend; old_mask = m_mask; old_mode = m_mode;
            offs = int'(bus.bus_addr) - int'(Base);
            m_hit = !we && offs >= 0 && offs <= 2;
            m_rdata = '0;
            if (m_hit) begin
                if (offs == 0) m_rdata = {4'b0, old_mask};
                else if (offs == 1) m_rdata = {4'b0, old_pend};
                else m_rdata = {7'b0, old_mode};
            end
            done = m_srv >= 0 && ack[m_srv];
            clr = '0;
            if (done) clr[m_srv] = 1'b1;
            if (we && offs == 1) clr = clr | bus.bus_wdata[3:0];
            m_pend = (old_pend & ~clr) | (req & ~m_req_prev);
            m_req_prev = req;
            if (we && offs == 0) m_mask = bus.bus_wdata[3:0];
            if (we && offs == 2) m_mode = bus.bus_wdata[0];
            if (m_srv >= 0) begin
                if (done) begin
                    m_rr = (m_srv + 1) % N; m_srv = -1; m_gap = 1;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else if ((old_pend & old_mask) != 0) begin
                m_srv = pick(old_pend & old_mask, old_mode, m_rr);
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("raise", 8'(bus.cpu_irq_raise), {4'b0, exp_raise()});
        check("rdata", bus.bus_rdata, m_rdata);
        check("rd_hit", 8'(bus.bus_rd_hit), {7'b0, m_hit});
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        bus.bus_addr = addr; bus.bus_wdata = data; bus.bus_we = 1'b1;
        tick();
        bus.bus_addr = 8'h00; bus.bus_wdata = 8'h00; bus.bus_we = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        bus.bus_addr = addr; bus.bus_we = 1'b0;
        tick();
        bus.bus_addr = 8'h00;
        check(tag, bus.bus_rdata, exp);
        check({tag, "_hit"}, 8'(bus.bus_rd_hit), 8'h01);
    endtask

    task automatic pulse(input logic [3:0] req);
        bus.irq_req = req;
        tick();
        bus.irq_req = '0;
    endtask

    task automatic wait_raise(input string tag, input logic [3:0] exp);
        for (int i = 0; i < 20; i++) begin
            if (bus.cpu_irq_raise != '0) break;
            tick();
        end
        check(tag, 8'(bus.cpu_irq_raise), {4'b0, exp});
    endtask

    task automatic ack(input logic [3:0] a);
        bus.cpu_irq_ack = a;
        tick();
        bus.cpu_irq_ack = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.irq_req = '0; bus.cpu_irq_ack = '0;
        bus.bus_addr = 8'h00; bus.bus_wdata = 8'h00; bus.bus_we = 1'b0;
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        read_check("rst_mask", Base, 8'h0F);
        read_check("rst_pend", Base + 8'd1, 8'h00);
        read_check("rst_mode", Base + 8'd2, 8'h00);

        // Single request: raise two edges after the request edge, cleared by ack.
        pulse(4'b0100);
        check("t1_lat1", 8'(bus.cpu_irq_raise), 8'h00);
        tick();
        check("t1_raise", 8'(bus.cpu_irq_raise), 8'h04);
        tick(); tick();
        ack(4'b0100);
        check("t1_ack", 8'(bus.cpu_irq_raise), 8'h00);
        read_check("t1_pend", Base + 8'd1, 8'h00);

        // Simultaneous 0 and 3: fixed priority, then round-robin from rr_ptr=1.
        pulse(4'b1001);
        wait_raise("t2_fix_first", 4'b0001);
        ack(4'b0001);
        check("t2_gap", 8'(bus.cpu_irq_raise), 8'h00);
        wait_raise("t2_fix_second", 4'b1000);
        ack(4'b1000);
        pulse(4'b0001);
        wait_raise("t2_prep", 4'b0001);
        ack(4'b0001);
        bus_write(Base + 8'd2, 8'h01);
        pulse(4'b1001);
        wait_raise("t2_rr_first", 4'b1000);
        ack(4'b1000);
        wait_raise("t2_rr_second", 4'b0001);
        ack(4'b0001);
        bus_write(Base + 8'd2, 8'h00);

        // Masked events accumulate and fire once unmasked.
        bus_write(Base, 8'h0E);
        pulse(4'b0001);
        tick(); tick(); tick();
        check("t3_masked", 8'(bus.cpu_irq_raise), 8'h00);
        read_check("t3_pend", Base + 8'd1, 8'h01);
        bus_write(Base, 8'h0F);
        wait_raise("t3_unmask", 4'b0001);
        ack(4'b0001);

        // Wrong-bit ack ignored; edge coincident with ack keeps the source pending.
        pulse(4'b0010);
        wait_raise("t4_raise", 4'b0010);
        ack(4'b0001);
        check("t4_wrong_ack", 8'(bus.cpu_irq_raise), 8'h02);
        bus.irq_req = 4'b0010; bus.cpu_irq_ack = 4'b0010;
        tick();
        bus.irq_req = '0; bus.cpu_irq_ack = '0;
        check("t4_ack", 8'(bus.cpu_irq_raise), 8'h00);
        read_check("t4_pend", Base + 8'd1, 8'h02);
        wait_raise("t4_reraise", 4'b0010);
        ack(4'b0010);

        // Reset while raised.
        pulse(4'b0100);
        wait_raise("t5_raise", 4'b0100);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t5_raise_clr", 8'(bus.cpu_irq_raise), 8'h00);
        read_check("t5_pend", Base + 8'd1, 8'h00);
        read_check("t5_mask", Base, 8'h0F);

        // Round-robin fairness with every source kept pending.
        bus_write(Base + 8'd2, 8'h01);
        pulse(4'b1111);
        begin
            int order [5] = '{0, 1, 2, 3, 0};
            for (int i = 0; i < 5; i++) begin
                logic [3:0] oh;
                oh = 4'(1 << order[i]);
                wait_raise("t6_order", oh);
                bus.irq_req = oh; bus.cpu_irq_ack = oh;
                tick();
                bus.irq_req = '0; bus.cpu_irq_ack = '0;
            end
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            int r;
            bus.irq_req = 4'($urandom & $urandom);
            bus.cpu_irq_ack = '0;
            if (bus.cpu_irq_raise != '0 && $urandom_range(0, 2) == 0)
                bus.cpu_irq_ack = bus.cpu_irq_raise;
            else if ($urandom_range(0, 9) == 0)
                bus.cpu_irq_ack = 4'($urandom);
            r = int'($urandom_range(0, 7));
            bus.bus_we = 1'b0; bus.bus_addr = 8'h00; bus.bus_wdata = 8'($urandom);
            if (r == 0) begin
                bus.bus_we = 1'b1;
                bus.bus_addr = Base + 8'($urandom_range(0, 3));
            end else if (r <= 2) begin
                bus.bus_addr = 8'hDE + 8'($urandom_range(0, 5));
            end
            reset_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        reset_n = 1'b1;
        bus.irq_req = '0; bus.cpu_irq_ack = '0;
        bus.bus_we = 1'b0; bus.bus_addr = 8'h00;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
